// File: rtl/down_timer.sv
// down_timer: loadable down-counting timer with one-shot and periodic modes.
// A terminal-count pulse is issued on the enabled cycle that finds the count
// at zero; the timer then stops in DONE or reloads and keeps running.
// All outputs come straight from registers.
module down_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             start,
    input  logic             enable,
    input  logic             periodic,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] reload_q;
    logic             tc_q;

    // State, count, reload and terminal pulse; priority is reset, load, start, enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            tc_q <= 1'b0;
            if (load) begin
                count_q  <= data;
                reload_q <= data;
                state_q  <= start ? RUN : IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            state_q <= RUN;
                        end
                    end
                    DONE: begin
                        if (start) begin
                            state_q <= RUN;
                            count_q <= reload_q;
                        end
                    end
                    RUN: begin
                        if (enable) begin
                            if (count_q != '0) begin
                                count_q <= count_q - WIDTH'(1);
                            end else begin
                                // Zero is terminal, so the decrement never wraps.
                                tc_q <= 1'b1;
                                if (periodic) begin
                                    count_q <= reload_q;
                                end else begin
                                    state_q <= DONE;
                                end
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);

endmodule

// File: tb/tb_down_timer.sv
// Directed bench for down_timer: a behavioural model tracks mode, count and
// reload from the operational rules and is compared on every edge; literal
// expectations at key points pin the model itself.
module tb_down_timer;

    logic       clk = 1'b0;
    logic       reset, load, start, enable, periodic;
    logic [3:0] data;
    logic [3:0] count;
    logic       tc, busy, done;

    int checks   = 0;
    int failures = 0;

    // Model: mode 0 = idle, 1 = running, 2 = finished.
    int m_mode = 0;
    int m_cnt  = 0;
    int m_rel  = 0;
    int m_tc   = 0;

    down_timer #(.WIDTH(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .start   (start),
        .enable  (enable),
        .periodic(periodic),
        .data    (data),
        .count   (count),
        .tc      (tc),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural rules applied to the inputs seen at one rising edge.
    task automatic model_edge();
        if (reset === 1'b1) begin
            m_mode = 0; m_cnt = 0; m_rel = 0; m_tc = 0;
        end else begin
            m_tc = 0;
            if (load) begin
                m_cnt  = int'(data);
                m_rel  = int'(data);
                m_mode = start ? 1 : 0;
            end else if (start && m_mode != 1) begin
                if (m_mode == 2) m_cnt = m_rel;
                m_mode = 1;
            end else if (m_mode == 1 && enable) begin
                if (m_cnt > 0) begin
                    m_cnt = m_cnt - 1;
                end else begin
                    m_tc = 1;
                    if (periodic) m_cnt = m_rel;
                    else m_mode = 2;
                end
            end
        end
    endtask

    // One clock edge: update the model, then compare all outputs after the edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("count", 32'(count), 32'(m_cnt));
        check("tc",    32'(tc),    32'(m_tc));
        check("busy",  32'(busy),  32'(m_mode == 1));
        check("done",  32'(done),  32'(m_mode == 2));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drive(input logic l, input logic s, input logic e, input logic p, input logic [3:0] d);
        load = l; start = s; enable = e; periodic = p; data = d;
    endtask

    initial begin
        // Reset with every other input unknown.
        reset = 1'b1;
        load = 1'bx; start = 1'bx; enable = 1'bx; periodic = 1'bx; data = 4'bx;
        step();
        check("rst_count", 32'(count), 32'h0);
        check("rst_tc",    32'(tc),    32'h0);
        check("rst_busy",  32'(busy),  32'h0);
        check("rst_done",  32'(done),  32'h0);
        reset = 1'b0;

        // One-shot from 5.
        drive(1, 0, 0, 0, 4'd5); step();
        check("load_lat", 32'(count), 32'h5);
        drive(0, 1, 0, 0, 4'd0); step();
        drive(0, 0, 1, 0, 4'd0);
        steps(5);
        check("os_zero", 32'(count), 32'h0);
        step();
        check("os_tc",   32'(tc),   32'h1);
        check("os_done", 32'(done), 32'h1);
        check("os_busy", 32'(busy), 32'h0);
        steps(2);
        check("os_after_tc", 32'(tc), 32'h0);

        // Start in DONE with reload 9 restores the reload value.
        drive(1, 1, 0, 0, 4'd9); step();
        drive(0, 0, 1, 0, 4'd0); steps(10);
        check("d9_done", 32'(done), 32'h1);
        drive(0, 1, 0, 0, 4'd0); step();
        check("done_restart", 32'(count), 32'h9);
        check("done_restart_busy", 32'(busy), 32'h1);

        // Periodic with reload 3: load+start together, enable ignored on load edge.
        drive(1, 1, 1, 1, 4'd3); step();
        check("per_load", 32'(count), 32'h3);
        drive(0, 0, 1, 1, 4'd0); steps(4);
        check("per_tc",    32'(tc),    32'h1);
        check("per_count", 32'(count), 32'h3);
        check("per_busy",  32'(busy),  32'h1);
        steps(8);

        // Enable gating at 7.
        drive(1, 1, 0, 0, 4'd7); step();
        drive(0, 0, 0, 0, 4'd0); steps(10);
        check("gate_hold", 32'(count), 32'h7);
        drive(0, 0, 1, 0, 4'd0); step();
        check("gate_resume", 32'(count), 32'h6);
        steps(2);
        check("at_four", 32'(count), 32'h4);

        // Load during RUN stops the timer.
        drive(1, 0, 1, 0, 4'hf); step();
        check("load_run_cnt",  32'(count), 32'hf);
        check("load_run_busy", 32'(busy),  32'h0);

        // Start in RUN has no effect.
        drive(0, 1, 0, 0, 4'd0); step();
        step();
        check("start_in_run", 32'(count), 32'hf);

        // Reload 0 periodic: tc on every enabled edge.
        drive(1, 1, 0, 1, 4'd0); step();
        drive(0, 0, 1, 1, 4'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("zero_per_tc", 32'(tc), 32'h1);
        end

        // Reset coinciding with the terminal edge.
        drive(1, 1, 0, 0, 4'd2); step();
        drive(0, 0, 1, 0, 4'd0); steps(2);
        check("pre_term", 32'(count), 32'h0);
        reset = 1'b1; step();
        check("rst_term_tc",   32'(tc),    32'h0);
        check("rst_term_busy", 32'(busy),  32'h0);
        reset = 1'b0;
        drive(0, 1, 0, 0, 4'd0); step();
        drive(0, 0, 1, 0, 4'd0); step();
        check("post_rst_tc", 32'(tc), 32'h1);
        steps(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
